// File: rtl/tdc_seq_pkg.sv
// tdc_seq_pkg: shared state type, default header and parameter limits for the TDC byte sequencer.
package tdc_seq_pkg;
   typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_GAPW} tdc_state_e;
   localparam logic [7:0] TDC_HDR_DEF = 8'hA5;
   localparam int TDC_WB_MAX = 8;
   localparam int TDC_GAP_MAX = 15;
   localparam int TDC_CNT_W = 4;
endpackage

// File: rtl/tdc_gap_cnt.sv
// tdc_gap_cnt: loadable down-counter timing the inter-byte wait; done while the count is zero.
module tdc_gap_cnt
   import tdc_seq_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_i,
   input  logic [TDC_CNT_W-1:0] val_i,
   output logic                 done_o
);
   logic [TDC_CNT_W-1:0] cnt_q, cnt_d;
   assign done_o = cnt_q == '0;
   always_comb cnt_d = load_i ? val_i : (done_o ? cnt_q : cnt_q - 1'b1);
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/tdc_byte_seq.sv
// tdc_byte_seq: replays one hit word as a strobed byte frame (header, data MSB-first, optional checksum).
// Define TDC_SEQ_CSUM_EN to append an XOR checksum byte to every frame.
module tdc_byte_seq
   import tdc_seq_pkg::*;
#(
   parameter int         WORD_BYTES = 4,
   parameter int         GAP        = 0,
   parameter logic [7:0] HDR        = TDC_HDR_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   input  logic [8*WORD_BYTES-1:0] in_data,
   output logic                    in_ready,
   output logic [7:0]              Dout,
   output logic                    en,
   output logic                    frame_done,
   output logic                    busy
);
   localparam int DW = 8*WORD_BYTES;
   localparam logic [TDC_CNT_W-1:0] GAP_LD = TDC_CNT_W'(GAP > 0 ? GAP - 1 : 0);
   if (WORD_BYTES < 1 || WORD_BYTES > TDC_WB_MAX || GAP < 0 || GAP > TDC_GAP_MAX) begin : g_bad_param
      $error("tdc_byte_seq: WORD_BYTES or GAP out of range");
   end
   tdc_state_e state_q, state_d, prev_q, prev_d, nxt_st;
   logic [DW-1:0] sr_q, sr_d;
   logic [TDC_CNT_W-1:0] idx_q, idx_d;
   logic [7:0] dout_q, dout_d, nxt_b;
   logic en_q, en_d, fd_q, fd_d, nxt_fd, more, emit, gap_ld, gap_done;
`ifdef TDC_SEQ_CSUM_EN
   logic [7:0] csum_q, csum_d;
`endif
   tdc_gap_cnt u_gap (.clk(clk), .reset(reset), .load_i(gap_ld), .val_i(GAP_LD), .done_o(gap_done));
   // prev_q remembers the last strobed byte kind so GAPW knows what comes next
   always_comb begin
      more = (prev_q == S_HDR || prev_q == S_DATA) && idx_q != '0;
      nxt_st = S_DATA;
      nxt_b = sr_q[DW-1 -: 8];
`ifdef TDC_SEQ_CSUM_EN
      nxt_fd = 1'b0;
      if (prev_q == S_DATA && idx_q == '0) begin
         more = 1'b1;
         nxt_st = S_CSUM;
         nxt_b = csum_q;
         nxt_fd = 1'b1;
      end
`else
      nxt_fd = idx_q == TDC_CNT_W'(1);
`endif
   end
   always_comb begin
      state_d = state_q;
      prev_d = prev_q;
      sr_d = sr_q;
      idx_d = idx_q;
      dout_d = dout_q;
      en_d = 1'b0;
      fd_d = 1'b0;
      gap_ld = 1'b0;
      emit = 1'b0;
`ifdef TDC_SEQ_CSUM_EN
      csum_d = csum_q;
`endif
      if (state_q == S_IDLE) begin
         if (in_valid && in_ready) begin
            state_d = S_HDR;
            prev_d = S_HDR;
            sr_d = in_data;
            idx_d = TDC_CNT_W'(WORD_BYTES);
            dout_d = HDR;
            en_d = 1'b1;
`ifdef TDC_SEQ_CSUM_EN
            csum_d = '0;
`endif
         end
      end else if (!more) state_d = S_IDLE;
      else if (state_q != S_GAPW && GAP > 0) begin
         state_d = S_GAPW;
         gap_ld = 1'b1;
      end else emit = state_q != S_GAPW || gap_done;
      if (emit) begin
         state_d = nxt_st;
         prev_d = nxt_st;
         dout_d = nxt_b;
         en_d = 1'b1;
         fd_d = nxt_fd;
         if (nxt_st == S_DATA) begin
            sr_d = sr_q << 8;
            idx_d = idx_q - 1'b1;
`ifdef TDC_SEQ_CSUM_EN
            csum_d = csum_q ^ nxt_b;
`endif
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         prev_q <= S_IDLE;
         sr_q <= '0;
         idx_q <= '0;
         dout_q <= '0;
         en_q <= 1'b0;
         fd_q <= 1'b0;
`ifdef TDC_SEQ_CSUM_EN
         csum_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         prev_q <= prev_d;
         sr_q <= sr_d;
         idx_q <= idx_d;
         dout_q <= dout_d;
         en_q <= en_d;
         fd_q <= fd_d;
`ifdef TDC_SEQ_CSUM_EN
         csum_q <= csum_d;
`endif
      end
   end
   assign in_ready = state_q == S_IDLE && !reset;
   assign busy = state_q != S_IDLE;
   assign Dout = dout_q;
   assign en = en_q;
   assign frame_done = fd_q;
endmodule

// File: tb/tb_tdc_byte_seq.sv
// tb_tdc_byte_seq: scoreboard bench for tdc_byte_seq at GAP=0 and GAP=2 against a frame-level model.
module tb_tdc_byte_seq;
   typedef struct {
      int         cyc;
      logic [7:0] b;
      logic       last;
   } exp_t;
`ifdef TDC_SEQ_CSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif
   localparam int WB = 4;
   logic clk = 1'b0;
   int cyc = 0;
   int total = 0;
   int bad = 0;
   bit fin [2];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   for (genvar g = 0; g < 2; g++) begin : gi
      localparam int G = 2*g;
      logic reset = 1'b1;
      logic in_valid = 1'b0;
      logic [8*WB-1:0] in_data = '0;
      logic in_ready, en, frame_done, busy;
      logic [7:0] dout;
      exp_t q[$];
      exp_t e;
      logic [7:0] last_b = 8'h00;
      logic [7:0] x, b;
      bit post_rst = 1'b0;
      tdc_byte_seq #(.WORD_BYTES(WB), .GAP(G), .HDR(8'hA5)) u_dut (
         .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
         .Dout(dout), .en(en), .frame_done(frame_done), .busy(busy));
      // the model: a frame is a list of (cycle, byte, last) built from the accepted word
      always @(negedge clk) begin
         chk($sformatf("g%0d in_ready", g), in_ready, q.size() == 0 && !reset);
         chk($sformatf("g%0d busy", g), busy, q.size() != 0);
         if (post_rst) begin
            chk($sformatf("g%0d reset Dout", g), dout, 8'h00);
            chk($sformatf("g%0d reset en", g), en, 1'b0);
            post_rst = 1'b0;
         end
         if (en) begin
            if (q.size() == 0) chk($sformatf("g%0d spurious en", g), en, 1'b0);
            else begin
               e = q.pop_front();
               chk($sformatf("g%0d en cycle", g), cyc, e.cyc);
               chk($sformatf("g%0d Dout", g), dout, e.b);
               chk($sformatf("g%0d frame_done", g), frame_done, e.last);
               last_b = e.b;
            end
         end else begin
            chk($sformatf("g%0d frame_done idle", g), frame_done, 1'b0);
            if (q.size() != 0) begin
               chk($sformatf("g%0d Dout hold", g), dout, last_b);
               if (q[0].cyc <= cyc) begin
                  chk($sformatf("g%0d missed en", g), cyc, q[0].cyc);
                  void'(q.pop_front());
               end
            end
         end
         if (reset) begin
            q.delete();
            last_b = 8'h00;
            post_rst = 1'b1;
         end else if (in_valid && in_ready) begin
            x = 8'h00;
            q.push_back('{cyc + 1, 8'hA5, 1'b0});
            for (int j = 0; j < WB; j++) begin
               b = in_data[8*(WB-1-j) +: 8];
               x ^= b;
               q.push_back('{cyc + 1 + (j + 1)*(G + 1), b, (j == WB - 1) && !CS});
            end
            if (CS) q.push_back('{cyc + 1 + (WB + 1)*(G + 1), x, 1'b1});
         end
      end
      task automatic send(input logic [31:0] w, input bit churn);
         bit acc;
         in_valid = 1'b1;
         in_data = w;
         for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) return;
            if (churn) in_data = $urandom;
         end
         chk($sformatf("g%0d accept timeout", g), 1'b0, 1'b1);
      endtask
      task automatic settle();
         in_valid = 1'b0;
         repeat ((WB + 2)*(G + 1) + 3) @(posedge clk);
         #1;
      endtask
      task automatic pulse_reset();
         reset = 1'b1;
         @(posedge clk);
         #1;
         reset = 1'b0;
      endtask
      initial begin
         repeat (3) @(posedge clk);
         #1;
         reset = 1'b0;
         send(32'h12345678, 1'b0);
         settle();
         send(32'h0F0F00FF, 1'b0);
         settle();
         send(32'h00000001, 1'b0);
         send(32'h00000002, 1'b0);
         settle();
         send(32'hCAFEF00D, 1'b0);
         send($urandom, 1'b1);
         send($urandom, 1'b1);
         settle();
         send(32'hDEADBEEF, 1'b0);
         in_valid = 1'b0;
         repeat (2*(G + 1)) @(posedge clk);
         #1;
         pulse_reset();
         settle();
         for (int i = 0; i < 40; i++) begin
            send($urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) in_valid = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
               repeat ($urandom_range(0, 6)) @(posedge clk);
               #1;
               pulse_reset();
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
         settle();
         fin[g] = 1'b1;
      end
   end
   initial begin
      fork
         wait (fin[0] && fin[1]);
         begin
            #2_000_000;
            chk("run timeout", 1'b0, 1'b1);
         end
      join_any
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
